// File: rtl/bram_sdp_1clk.sv
// Single-clock simple-dual-port RAM with a registered, enabled read port.
// The read is read-first: a same-edge write to the read address returns the old word.
module bram_sdp_1clk #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // NOTE: the array has no reset so it maps onto block RAM; contents are only
  // trusted once written, and read-data validity is tracked by the caller.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its value while re is low, so it doubles as a skid slot.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// First-word-fall-through stream FIFO on an inferred BRAM, carrying a per-word SOF tag.
// A read-data slot plus an output register hide the one-cycle BRAM read latency.
module bram_stream_fifo #(
  parameter int DATA_WIDTH    = 12,
  parameter int DEPTH         = 1024,
  parameter int AFULL_THRESH  = 1000,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_sof,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_sof,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = DATA_WIDTH + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_pend;
  logic [WW-1:0] rd_word;
  logic          wr_en, pop, load, rd_en;
  logic [CW-1:0] unread;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    s_ready      = !rst && (count != CW'(DEPTH));
    overflow     = s_valid && !s_ready && !flush && !rst;
    wr_en        = s_valid && s_ready && !flush;
    pop          = m_valid && m_ready;
    // rd_pend means the BRAM read register holds a word not yet in the output stage.
    load         = rd_pend && (!m_valid || m_ready);
    unread       = count - CW'(rd_pend) - CW'(m_valid);
    rd_en        = !rst && !flush && (unread != '0) && (!rd_pend || load);
    almost_full  = int'(count) >= AFULL_THRESH;
    almost_empty = int'(count) <= AEMPTY_THRESH;
  end

  bram_sdp_1clk #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({s_sof, s_data}),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_pend <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(wr_en) - CW'(pop);

      if (rd_en)     rd_pend <= 1'b1;
      else if (load) rd_pend <= 1'b0;

      if (load) begin
        m_valid         <= 1'b1;
        {m_sof, m_data} <= rd_word;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Directed bench for bram_stream_fifo (DEPTH=8 instance) with a queue scoreboard on every pop.
module tb_bram_stream_fifo;

  localparam int DW = 12;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic [CW-1:0] count;
  logic          almost_full, almost_empty, overflow;

  bram_stream_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (6),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sof        (m_sof),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pops = 0;
  int sof_pops = 0;
  logic [DW:0] exp_q[$];
  logic        hold_valid = 1'b0;
  logic [DW:0] hold_word = '0;
  logic        wr_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle's handshakes into the scoreboard, then advances one clock.
  task automatic tick();
    logic [DW:0] e;
    #1;
    wr_acc = 1'b0;
    if (rst || flush) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid)
        check("stall_hold", 32'({m_valid, m_sof, m_data}), 32'({1'b1, hold_word}));
      if (m_valid && m_ready) begin
        pops++;
        if (m_sof) sof_pops++;
        check("pop_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pop_word", 32'({m_sof, m_data}), 32'(e));
        end
      end
      hold_valid = m_valid && !m_ready;
      hold_word  = {m_sof, m_data};
      wr_acc = s_valid && s_ready;
      if (wr_acc) exp_q.push_back({s_sof, s_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(base + i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, sof0, bad, sent, cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    check("post_rst_aempty", 32'(almost_empty), 32'd1);
    check("post_rst_afull", 32'(almost_full), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_m_data", 32'({m_sof, m_data}), 32'd0);
    check("post_rst_overflow", 32'(overflow), 32'd0);

    // Test 1: three words, 2-clock latency, back-to-back output
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 12'h001; tick();
    check("t1_lat_edge0", 32'(m_valid), 32'd0);
    s_data = 12'h002; tick();
    check("t1_lat_edge1", 32'(m_valid), 32'd0);
    s_data = 12'h003; tick();
    check("t1_valid_edge2", 32'(m_valid), 32'd1);
    check("t1_first_word", 32'(m_data), 32'h001);
    check("t1_count3", 32'(count), 32'd3);
    s_valid = 1'b0; tick();
    check("t1_second_word", 32'({m_valid, m_data}), 32'h1002);
    tick();
    check("t1_third_word", 32'({m_valid, m_data}), 32'h1003);
    tick();
    check("t1_empty_valid", 32'(m_valid), 32'd0);
    check("t1_empty_count", 32'(count), 32'd0);

    // Test 2: fill to full with consumer stalled, overflow, then drain
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 12'(12'h100 + i); tick();
      if (i == 1) check("t2_aempty_at2", 32'(almost_empty), 32'd1);
      if (i == 2) check("t2_aempty_at3", 32'(almost_empty), 32'd0);
      if (i == 4) check("t2_afull_at5", 32'(almost_full), 32'd0);
      if (i == 5) check("t2_afull_at6", 32'(almost_full), 32'd1);
    end
    check("t2_full_count", 32'(count), 32'd8);
    check("t2_full_s_ready", 32'(s_ready), 32'd0);
    check("t2_full_afull", 32'(almost_full), 32'd1);
    check("t2_head_word", 32'({m_valid, m_data}), 32'h1100);
    s_data = 12'h1FF;
    #1;
    check("t2_overflow_pulse", 32'(overflow), 32'd1);
    tick();
    s_valid = 1'b0;
    #1;
    check("t2_overflow_clear", 32'(overflow), 32'd0);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 12'h1FE;
    #1;
    check("t2_pop_no_comb_ready", 32'(s_ready), 32'd0);
    check("t2_pop_overflow", 32'(overflow), 32'd1);
    tick();
    s_valid = 1'b0;
    check("t2_count_after_pop", 32'(count), 32'd7);
    repeat (20) tick();
    check("t2_drain_count", 32'(count), 32'd0);
    check("t2_drain_pops", 32'(pops - p0), 32'd8);
    check("t2_drain_queue", 32'(exp_q.size()), 32'd0);

    // Tests 3+5: 1000-word stream, SOF on words 0 and 640
    m_ready = 1'b1;
    p0 = pops; sof0 = sof_pops; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'b1;
      s_data  = 12'(i * 7);
      s_sof   = (i == 0) || (i == 640);
      tick();
      if (i >= 2 && (!m_valid || count != CW'(3))) bad++;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    repeat (10) tick();
    check("t3_steady_state", 32'(bad), 32'd0);
    check("t3_pops", 32'(pops - p0), 32'd1000);
    check("t5_sof_pops", 32'(sof_pops - sof0), 32'd2);
    check("t3_final_count", 32'(count), 32'd0);

    // Test 4: 500 words under random back-pressure
    p0 = pops; sent = 0; cyc = 0;
    while ((sent < 500 || count != '0 || exp_q.size() != 0) && cyc < 4000) begin
      s_valid = (sent < 500);
      s_data  = 12'(sent * 13 + 5);
      m_ready = 1'($urandom_range(0, 1));
      tick();
      if (wr_acc) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    check("t4_within_budget", 32'(cyc < 4000), 32'd1);
    check("t4_pops", 32'(pops - p0), 32'd500);

    // Test 6a: flush with 5 words stored and a read pending
    m_ready = 1'b0;
    fill(5, 12'h200);
    check("t6_pre_count", 32'(count), 32'd5);
    flush = 1'b1; s_valid = 1'b1; s_data = 12'h2AA;
    #1;
    check("t6_flush_no_overflow", 32'(overflow), 32'd0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("t6_flush_m_valid", 32'(m_valid), 32'd0);
    check("t6_flush_count", 32'(count), 32'd0);
    check("t6_flush_m_data", 32'({m_sof, m_data}), 32'd0);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 12'h2BB; tick();
    s_valid = 1'b0;
    check("t6_new_lat0", 32'(m_valid), 32'd0);
    tick();
    check("t6_new_lat1", 32'(m_valid), 32'd0);
    tick();
    check("t6_new_word", 32'({m_valid, m_data}), 32'h12BB);
    tick();
    check("t6_no_stale", 32'({m_valid, count}), 32'd0);

    // Test 6b: flush while full with s_valid high
    m_ready = 1'b0;
    fill(8, 12'h300);
    flush = 1'b1; s_valid = 1'b1; s_data = 12'h3AA;
    #1;
    check("t6_full_flush_no_overflow", 32'(overflow), 32'd0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("t6_full_flush_count", 32'(count), 32'd0);
    check("t6_full_flush_ready", 32'(s_ready), 32'd1);

    // Test 6c: reset with 5 words stored
    fill(5, 12'h400);
    rst = 1'b1; s_valid = 1'b1; s_data = 12'h4AA;
    #1;
    check("t6_rst_s_ready", 32'(s_ready), 32'd0);
    tick();
    rst = 1'b0; s_valid = 1'b0;
    check("t6_rst_state", 32'({m_valid, count}), 32'd0);
    check("t6_rst_aempty", 32'(almost_empty), 32'd1);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 12'h4CC; tick();
    s_valid = 1'b0;
    tick();
    check("t6_rst_lat1", 32'(m_valid), 32'd0);
    tick();
    check("t6_rst_new_word", 32'({m_valid, m_data}), 32'h14CC);
    repeat (3) tick();
    check("t6_rst_final_count", 32'(count), 32'd0);
    check("t6_rst_final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
